vector_writeback_arbiter: RTL
=============================

VECTOR_WRITEBACK_ARBITER -- requirements
Module: vector_writeback_arbiter

Interface
REQ-001 SHALL have parameter REG_IDX_WIDTH, default 7, register index width (4 strands x 32 registers).
REQ-002 SHALL have parameter VECTOR_LANES, default 16, number of 32-bit lanes; VECTOR_BITS = 32*VECTOR_LANES.
REQ-003 SHALL have port clk, input, 1, the single clock; all state SHALL be rising-edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports req0_valid / req1_valid, input, 1 each, writeback request from requester 0 (execute pipeline) and requester 1 (load return).
REQ-006 SHALL have ports req0_reg / req1_reg, input, REG_IDX_WIDTH each, destination register.
REQ-007 SHALL have ports req0_value / req1_value, input, VECTOR_BITS each, write data.
REQ-008 SHALL have ports req0_mask / req1_mask, input, VECTOR_LANES each, per-lane write enable.
REQ-009 SHALL have ports req0_ready / req1_ready, output, 1 each, request accepted this cycle.
REQ-010 SHALL have port clear_start, input, 1, one-cycle pulse requesting a full register-file clear.
REQ-011 SHALL have port clear_busy, output, 1, clear sequence in progress.
REQ-012 SHALL have ports wb_writeback_reg (REG_IDX_WIDTH), wb_writeback_value (VECTOR_BITS), wb_writeback_mask (VECTOR_LANES), wb_enable_vector_writeback (1), all outputs, all registered, driving the vector register file write port.

Function
REQ-013 SHALL implement two states: CLEAR and RUN.
REQ-014 In CLEAR, SHALL issue one write per cycle to register clear_idx with value 0, mask all-ones, enable 1; clear_idx SHALL increment 0 to 2^REG_IDX_WIDTH-1.
REQ-015 After the write of the last index is issued, SHALL enter RUN next cycle; clear_idx SHALL wrap to 0; clear_busy SHALL deassert in the same cycle as the RUN entry.
REQ-016 In CLEAR, req0_ready and req1_ready SHALL be 0; pending requests SHALL be held by requesters, never dropped.
REQ-017 In RUN, a clear_start pulse SHALL move the FSM to CLEAR with clear_idx=0 next cycle; a request granted in the same cycle SHALL still complete; clear_start during CLEAR SHALL be ignored (no restart).
REQ-018 Transfer SHALL occur when reqN_valid and reqN_ready are both 1; ready SHALL be combinational from valid, state and priority pointer, and SHALL never depend on ready of the other port.
REQ-019 Requesters SHALL hold reg/value/mask stable while valid is high and ready is low.
REQ-020 In RUN, with one valid request, that request SHALL be granted the same cycle.
REQ-021 In RUN, with both valid, the requester indicated by the 1-bit priority pointer SHALL be granted; after any grant the pointer SHALL point to the non-granted requester.
REQ-022 At most one ready SHALL be high per cycle.
REQ-023 A granted request SHALL appear on wb_* exactly 1 cycle after the transfer, with wb_enable_vector_writeback=1 for that one cycle only.
REQ-024 A granted request with mask all-zero SHALL be accepted and SHALL produce wb_enable_vector_writeback=0 (no write).
REQ-025 In cycles with no grant and no clear write, wb_enable_vector_writeback SHALL be 0; the other wb_* outputs SHALL hold their previous values.
REQ-026 Back-to-back grants SHALL sustain one writeback per cycle with no bubble.

Reset
REQ-027 On reset low, asynchronously: state=CLEAR, clear_idx=0, priority pointer=0 (requester 0 favoured), clear_busy=1, wb_enable_vector_writeback=0, wb_writeback_reg=0, wb_writeback_value=0, wb_writeback_mask=0.
REQ-028 Reset asserted mid-clear or mid-transfer SHALL abort the operation; after release the clear SHALL restart from index 0; the first clear write SHALL appear 1 cycle after the first clock edge with reset high.

Verification
REQ-029 Release reset, hold req0_valid=1 -> 128 consecutive writes, reg 0..127, value 0, mask 0xFFFF; clear_busy falls after reg 127; req0_ready=1 in the first RUN cycle.
REQ-030 RUN, both valid for 4 cycles (req0 reg 5, req1 reg 9) -> grants alternate 0,1,0,1; wb_writeback_reg sequence 5,9,5,9, each 1 cycle after its grant.
REQ-031 RUN, req1 only, mask 0x0000 -> req1_ready=1; next cycle wb_enable_vector_writeback=0.
REQ-032 RUN, req0 granted in the same cycle as clear_start -> req0's write appears next cycle, followed by the clear writes for indices 0..127; ready stays 0 until the clear completes.
REQ-033 Reset low at clear_idx=60 for 1 cycle -> outputs reset immediately; after release the clear restarts at index 0.
REQ-034 Every scenario: assert never both readys high, and wb_enable_vector_writeback never high in a cycle that does not follow a grant or a clear write.

Source files
------------

// File: rtl/vector_writeback_arbiter.sv
// Vector register file writeback arbiter: round-robin between the execute pipeline
// and load return, with a full register-file clear sequence after reset or on request.
module vector_writeback_arbiter #(
    parameter int REG_IDX_WIDTH = 7,
    parameter int VECTOR_LANES  = 16,
    localparam int VECTOR_BITS  = 32 * VECTOR_LANES
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req0_valid,
    input  logic [REG_IDX_WIDTH-1:0] req0_reg,
    input  logic [VECTOR_BITS-1:0]   req0_value,
    input  logic [VECTOR_LANES-1:0]  req0_mask,
    output logic                     req0_ready,
    input  logic                     req1_valid,
    input  logic [REG_IDX_WIDTH-1:0] req1_reg,
    input  logic [VECTOR_BITS-1:0]   req1_value,
    input  logic [VECTOR_LANES-1:0]  req1_mask,
    output logic                     req1_ready,
    input  logic                     clear_start,
    output logic                     clear_busy,
    output logic [REG_IDX_WIDTH-1:0] wb_writeback_reg,
    output logic [VECTOR_BITS-1:0]   wb_writeback_value,
    output logic [VECTOR_LANES-1:0]  wb_writeback_mask,
    output logic                     wb_enable_vector_writeback
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam logic [REG_IDX_WIDTH-1:0] IDX_LAST = {REG_IDX_WIDTH{1'b1}};
    localparam logic [REG_IDX_WIDTH-1:0] IDX_ONE  = {{(REG_IDX_WIDTH-1){1'b0}}, 1'b1};

    state_t                   state_r;
    logic [REG_IDX_WIDTH-1:0] clear_idx_r;
    logic                     prio_r;
    logic                     grant0_s;
    logic                     grant1_s;

    // Grant selection: a lone requester wins outright, the pointer breaks ties.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (state_r == ST_RUN) begin
            if (req0_valid && (!req1_valid || (prio_r == 1'b0))) begin
                grant0_s = 1'b1;
            end else if (req1_valid) begin
                grant1_s = 1'b1;
            end else begin
                grant0_s = 1'b0;
                grant1_s = 1'b0;
            end
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    assign req0_ready = grant0_s;
    assign req1_ready = grant1_s;

    // Controller FSM and registered write port; the enable defaults low every cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r                    <= ST_CLEAR;
            clear_idx_r                <= '0;
            prio_r                     <= 1'b0;
            clear_busy                 <= 1'b1;
            wb_writeback_reg           <= '0;
            wb_writeback_value         <= '0;
            wb_writeback_mask          <= '0;
            wb_enable_vector_writeback <= 1'b0;
        end else begin
            wb_enable_vector_writeback <= 1'b0;
            case (state_r)
                ST_CLEAR: begin
                    wb_writeback_reg           <= clear_idx_r;
                    wb_writeback_value         <= '0;
                    wb_writeback_mask          <= '1;
                    wb_enable_vector_writeback <= 1'b1;
                    if (clear_idx_r == IDX_LAST) begin
                        state_r     <= ST_RUN;
                        clear_idx_r <= '0;
                        clear_busy  <= 1'b0;
                    end else begin
                        clear_idx_r <= clear_idx_r + IDX_ONE;
                    end
                end
                ST_RUN: begin
                    if (grant0_s) begin
                        wb_writeback_reg           <= req0_reg;
                        wb_writeback_value         <= req0_value;
                        wb_writeback_mask          <= req0_mask;
                        wb_enable_vector_writeback <= |req0_mask;
                        prio_r                     <= 1'b1;
                    end else if (grant1_s) begin
                        wb_writeback_reg           <= req1_reg;
                        wb_writeback_value         <= req1_value;
                        wb_writeback_mask          <= req1_mask;
                        wb_enable_vector_writeback <= |req1_mask;
                        prio_r                     <= 1'b0;
                    end else begin
                        prio_r <= prio_r;
                    end
                    // The grant taken alongside a clear request still lands first.
                    if (clear_start) begin
                        state_r     <= ST_CLEAR;
                        clear_idx_r <= '0;
                        clear_busy  <= 1'b1;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                default: begin
                    state_r     <= ST_CLEAR;
                    clear_idx_r <= '0;
                    clear_busy  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// Protocol checker for the arbiter: mutually exclusive grants and no spurious writes.
module vector_writeback_arbiter_checker (
    input logic clk,
    input logic reset,
    input logic req0_valid,
    input logic req0_ready,
    input logic req1_valid,
    input logic req1_ready,
    input logic clear_busy,
    input logic wb_enable_vector_writeback
);

    a_one_ready: assert property (@(posedge clk) disable iff (!reset)
        !(req0_ready && req1_ready))
        else $error("both ready outputs high");

    a_wb_source: assert property (@(posedge clk) disable iff (!reset)
        wb_enable_vector_writeback |->
            $past(clear_busy || (req0_valid && req0_ready) || (req1_valid && req1_ready)))
        else $error("write enable without a preceding grant or clear write");

endmodule
